// File: rtl/uart_mmio_pkg.sv
// Shared register offsets, STATUS bit positions and FSM encodings for uart_mmio.
// Also holds the divisor clamp helper used by the register decode.
package uart_mmio_pkg;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_RXDATA  = 2'd1;
  localparam logic [1:0] OFF_STATUS  = 2'd2;
  localparam logic [1:0] OFF_DIVISOR = 2'd3;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_TX_BUSY  = 2;
  localparam int ST_RX_VALID = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_OVR   = 5;
  localparam int ST_RX_FERR  = 6;

  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  // RX_BREAK holds off re-arming after a framing error until the line idles high.
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// Single-clock FIFO with count-based full/empty; pushes while full are dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign data_o    = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push_s) wptr_q <= wptr_q + AW'(1);
      if (do_pop_s)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TX FIFO + transmit FSM, synchronised receive FSM with
// a one-byte holding register, sticky error flags and a programmable divisor.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1FD0_0000,
  parameter int          DIVISOR_RST = 868,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        rxd_i,
  output logic        txd_o,
  output logic        irq_o
);
  logic        hit_s, wr_s, rd_s, tx_push_s, rx_pop_s, stat_clr_s, div_wr_s;
  logic [1:0]  off_s;
  logic [7:0]  fifo_data_s;
  logic        fifo_full_s, fifo_empty_s, tx_pop_s;
  logic [6:0]  status_s;
  logic        unused_s;

  tx_state_e   tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        txd_q;

  logic [1:0]  rx_sync_q;
  logic        rx_s, rx_done_s, rx_load_s, rx_ferr_evt_s;
  rx_state_e   rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;

  logic        rx_valid_q, rx_valid_d, tx_ovf_q, tx_ovf_d;
  logic        rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [15:0] div_q, div_d;

  assign hit_s      = ce_i & (addr_i[31:4] == BASE_ADDR[31:4]);
  assign off_s      = addr_i[3:2];
  assign wr_s       = hit_s & we_i;
  assign rd_s       = hit_s & ~we_i;
  assign tx_push_s  = wr_s & (off_s == OFF_TXDATA);
  assign rx_pop_s   = rd_s & (off_s == OFF_RXDATA);
  assign stat_clr_s = wr_s & (off_s == OFF_STATUS);
  assign div_wr_s   = wr_s & (off_s == OFF_DIVISOR);
  assign unused_s   = ^{addr_i[1:0], wdata_i[31:16], BASE_ADDR[3:0]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txfifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (tx_push_s),
    .data_i (wdata_i[7:0]),
    .pop_i  (tx_pop_s),
    .data_o (fifo_data_s),
    .full_o (fifo_full_s),
    .empty_o(fifo_empty_s)
  );

  // A pop happens from IDLE, or at the last STOP cycle so frames run back-to-back.
  assign tx_pop_s = ~fifo_empty_s &
                    ((tx_state_q == TX_IDLE) | ((tx_state_q == TX_STOP) & (tx_cnt_q == 16'd0)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      txd_q      <= 1'b1;
    end else if (tx_pop_s) begin
      tx_state_q <= TX_START;
      tx_cnt_q   <= div_q - 16'd1;
      tx_shift_q <= fifo_data_s;
      txd_q      <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: txd_q <= 1'b1;
        TX_START, TX_DATA, TX_STOP: begin
          if (tx_cnt_q != 16'd0) begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end else if (tx_state_q == TX_START) begin
            tx_state_q <= TX_DATA;
            tx_cnt_q   <= div_q - 16'd1;
            tx_bit_q   <= 3'd0;
            txd_q      <= tx_shift_q[0];
          end else if (tx_state_q == TX_DATA) begin
            tx_cnt_q   <= div_q - 16'd1;
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_bit_q   <= tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              txd_q      <= 1'b1;
            end else begin
              txd_q      <= tx_shift_q[1];
            end
          end else begin
            tx_state_q <= TX_IDLE;
            txd_q      <= 1'b1;
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          txd_q      <= 1'b1;
        end
      endcase
    end
  end

  assign rx_s          = rx_sync_q[1];
  assign rx_done_s     = (rx_state_q == RX_STOP) & (rx_cnt_q == 16'd0);
  assign rx_load_s     = rx_done_s & rx_s;
  assign rx_ferr_evt_s = rx_done_s & ~rx_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rxd_i};
      case (rx_state_q)
        RX_IDLE: if (!rx_s) begin
          rx_state_q <= RX_START;
          rx_cnt_q   <= {1'b0, div_q[15:1]} - 16'd1;
        end
        RX_START, RX_DATA, RX_STOP: begin
          if (rx_cnt_q != 16'd0) begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end else if (rx_state_q == RX_START) begin
            rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
            rx_cnt_q   <= div_q - 16'd1;
            rx_bit_q   <= 3'd0;
          end else if (rx_state_q == RX_DATA) begin
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            rx_cnt_q   <= div_q - 16'd1;
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_state_q <= rx_s ? RX_IDLE : RX_BREAK;
          end
        end
        RX_BREAK: if (rx_s) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Set events take priority over software clears of the sticky flags.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_byte_d  = rx_byte_q;
    if (rx_load_s) begin
      rx_valid_d = 1'b1;
      rx_byte_d  = rx_shift_q;
    end else if (rx_pop_s) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
    tx_ovf_d  = (tx_ovf_q  & ~(stat_clr_s & wdata_i[ST_TX_OVF]))  | (tx_push_s & fifo_full_s);
    rx_ovr_d  = (rx_ovr_q  & ~(stat_clr_s & wdata_i[ST_RX_OVR]))  | (rx_load_s & rx_valid_q & ~rx_pop_s);
    rx_ferr_d = (rx_ferr_q & ~(stat_clr_s & wdata_i[ST_RX_FERR])) | rx_ferr_evt_s;
    div_d     = div_wr_s ? clamp_div(wdata_i[15:0]) : div_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'd0;
      tx_ovf_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      div_q      <= 16'(DIVISOR_RST);
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
      div_q      <= div_d;
    end
  end

  always_comb begin
    status_s              = 7'd0;
    status_s[ST_TX_FULL]  = fifo_full_s;
    status_s[ST_TX_EMPTY] = fifo_empty_s;
    status_s[ST_TX_BUSY]  = (tx_state_q != TX_IDLE);
    status_s[ST_RX_VALID] = rx_valid_q;
    status_s[ST_TX_OVF]   = tx_ovf_q;
    status_s[ST_RX_OVR]   = rx_ovr_q;
    status_s[ST_RX_FERR]  = rx_ferr_q;
  end

  always_comb begin
    rdata_o = 32'd0;
    if (hit_s) begin
      case (off_s)
        OFF_RXDATA:  rdata_o = {rx_valid_q, 23'd0, rx_byte_q};
        OFF_STATUS:  rdata_o = {25'd0, status_s};
        OFF_DIVISOR: rdata_o = {16'd0, div_q};
        default:     rdata_o = 32'd0;
      endcase
    end else begin
      rdata_o = 32'd0;
    end
  end

  assign txd_o = txd_q;
  assign irq_o = rx_valid_q;

endmodule
